// File: rtl/lsu_pipe_if.sv
// lsu_pipe_if: bundles the execute-side op port, the writeback result port
// and the split request/response memory bus of lsu_pipe.
//   master : the load/store unit (drives e_ready, m_*, mem_req_*, mem_rsp_ready)
//   slave  : the surrounding pipeline and memory (drives everything else)
interface lsu_pipe_if #(
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 32,
  parameter int PADDR_WIDTH = 32
);
  localparam int STRB = DATA_WIDTH / 8;

  // execute -> unit
  logic                    e_valid;
  logic                    e_ready;
  logic                    e_regW;
  logic [ADDR_WIDTH-1:0]   e_regAddr;
  logic [DATA_WIDTH-1:0]   e_regData;
  logic [2:0]              e_load_inst;
  logic [2:0]              e_store_inst;
  logic [DATA_WIDTH-1:0]   e_store_data;

  // unit -> writeback
  logic                    m_valid;
  logic                    m_ready;
  logic                    m_regW;
  logic [ADDR_WIDTH-1:0]   m_regAddr;
  logic [DATA_WIDTH-1:0]   m_regData;
  logic                    m_fault;

  // memory request channel
  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic                    mem_req_we;
  logic [PADDR_WIDTH-1:0]  mem_req_addr;
  logic [DATA_WIDTH-1:0]   mem_req_wdata;
  logic [STRB-1:0]         mem_req_wstrb;

  // memory response channel
  logic                    mem_rsp_valid;
  logic                    mem_rsp_ready;
  logic [DATA_WIDTH-1:0]   mem_rsp_rdata;

  modport master (
    input  e_valid, e_regW, e_regAddr, e_regData, e_load_inst, e_store_inst, e_store_data,
    output e_ready,
    output m_valid, m_regW, m_regAddr, m_regData, m_fault,
    input  m_ready,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_rdata,
    output mem_rsp_ready
  );

  modport slave (
    output e_valid, e_regW, e_regAddr, e_regData, e_load_inst, e_store_inst, e_store_data,
    input  e_ready,
    input  m_valid, m_regW, m_regAddr, m_regData, m_fault,
    output m_ready,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_rdata,
    input  mem_rsp_ready
  );
endinterface

// File: rtl/lsu_pipe.sv
// lsu_pipe: multi-cycle load/store unit for the memory stage.
// Accepts one op at a time from execute, issues at most one memory
// transaction (split request/response, arbitrary latency), aligns sub-word
// data to byte lanes, sign/zero extends load data and flags misaligned or
// illegal-size accesses. Non-memory and faulting ops pass straight through
// into the output register in one cycle.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - lsu_pipe_if.master: e_* op input, m_* result output, mem_* bus
module lsu_pipe #(
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 32,
  parameter int PADDR_WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  lsu_pipe_if.master bus
);
  localparam int STRB = DATA_WIDTH / 8;
  localparam int OFF  = $clog2(STRB);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t state_q, state_d;

  // ---------------------------------------------------------------- decode
  logic       dec_load, dec_mem, dec_signed, dec_illegal, dec_misalign, dec_fault;
  logic [1:0] dec_lsize;   // log2 of access size in bytes
  logic [2:0] dec_amask;

  always_comb begin
    dec_load    = (bus.e_load_inst != 3'd0);
    dec_mem     = dec_load || (bus.e_store_inst != 3'd0);
    dec_lsize   = 2'd0;
    dec_signed  = 1'b0;
    dec_illegal = 1'b0;
    if (dec_load) begin
      // load code wins; the store code is ignored entirely, legal or not
      case (bus.e_load_inst)
        3'd1:    begin dec_lsize = 2'd0; dec_signed = 1'b1; end
        3'd2:    begin dec_lsize = 2'd1; dec_signed = 1'b1; end
        3'd3:    begin dec_lsize = 2'd2; dec_signed = 1'b1; end
        3'd4:    dec_lsize = 2'd0;
        3'd5:    dec_lsize = 2'd1;
        3'd6:    begin dec_lsize = 2'd2; dec_illegal = (DATA_WIDTH == 32); end
        default: begin dec_lsize = 2'd3; dec_signed = 1'b1; dec_illegal = (DATA_WIDTH == 32); end
      endcase
    end else begin
      case (bus.e_store_inst)
        3'd0:    dec_lsize = 2'd0;
        3'd1:    dec_lsize = 2'd0;
        3'd2:    dec_lsize = 2'd1;
        3'd3:    dec_lsize = 2'd2;
        3'd4:    begin dec_lsize = 2'd3; dec_illegal = (DATA_WIDTH == 32); end
        default: dec_illegal = 1'b1;
      endcase
    end
    case (dec_lsize)
      2'd0:    dec_amask = 3'b000;
      2'd1:    dec_amask = 3'b001;
      2'd2:    dec_amask = 3'b011;
      default: dec_amask = 3'b111;
    endcase
    // non-memory ops decode to size 1, so they never report misalignment
    dec_misalign = |(bus.e_regData[2:0] & dec_amask);
    dec_fault    = dec_illegal || dec_misalign;
  end

  // ------------------------------------------------------------- handshake
  logic m_valid_q, m_valid_d;
  logic m_regW_q, m_regW_d;
  logic m_fault_q, m_fault_d;
  logic [ADDR_WIDTH-1:0] m_regAddr_q, m_regAddr_d;
  logic [DATA_WIDTH-1:0] m_regData_q, m_regData_d;

  logic accept, pass_through, start, rsp_fire;

  always_comb begin
    accept       = bus.e_valid && bus.e_ready;
    pass_through = accept && (!dec_mem || dec_fault);
    start        = accept && dec_mem && !dec_fault;
    rsp_fire     = (state_q == WAIT) && bus.mem_rsp_valid;
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = REQ;
      REQ:     if (bus.mem_req_ready) state_d = WAIT;
      WAIT:    if (bus.mem_rsp_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.e_ready       = (state_q == IDLE) && (!m_valid_q || bus.m_ready);
    bus.mem_req_valid = (state_q == REQ);
    bus.mem_rsp_ready = (state_q == WAIT);
  end

  // ------------------------------------------------------ latched op fields
  logic                   ld_q, sign_q, regW_q;
  logic [1:0]             lsize_q;
  logic [OFF-1:0]         off_q;
  logic [ADDR_WIDTH-1:0]  regAddr_q;
  logic [PADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]  sdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_q      <= 1'b0;
      sign_q    <= 1'b0;
      regW_q    <= 1'b0;
      lsize_q   <= '0;
      off_q     <= '0;
      regAddr_q <= '0;
      addr_q    <= '0;
      sdata_q   <= '0;
    end else if (start) begin
      ld_q      <= dec_load;
      sign_q    <= dec_signed;
      regW_q    <= bus.e_regW;
      lsize_q   <= dec_lsize;
      off_q     <= bus.e_regData[OFF-1:0];
      regAddr_q <= bus.e_regAddr;
      addr_q    <= PADDR_WIDTH'(bus.e_regData);
      sdata_q   <= bus.e_store_data;
    end
  end

  // ------------------------------------------------------- request fields
  logic [STRB-1:0] strb_base;

  always_comb begin
    strb_base = '0;
    for (int unsigned i = 0; i < STRB; i++)
      strb_base[i] = !ld_q && (i < (32'd1 << lsize_q));
    bus.mem_req_we    = !ld_q;
    bus.mem_req_addr  = addr_q & ~(PADDR_WIDTH'(STRB - 1));
    bus.mem_req_wdata = sdata_q << {off_q, 3'b000};
    bus.mem_req_wstrb = strb_base << off_q;
  end

  // ---------------------------------------------------- load data extract
  logic [DATA_WIDTH-1:0] lane, ld_data;
  logic                  ld_sbit;
  int unsigned           ld_nbits;

  always_comb begin
    lane     = bus.mem_rsp_rdata >> {off_q, 3'b000};
    ld_nbits = 32'd8 << lsize_q;
    case (lsize_q)
      2'd0:    ld_sbit = lane[7];
      2'd1:    ld_sbit = lane[15];
      2'd2:    ld_sbit = lane[31];
      default: ld_sbit = lane[DATA_WIDTH-1];
    endcase
    ld_data = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++)
      ld_data[i] = (i < ld_nbits) ? lane[i] : (sign_q & ld_sbit);
  end

  // ------------------------------------------------------- output register
  always_comb begin
    m_valid_d   = m_valid_q;
    m_regW_d    = m_regW_q;
    m_fault_d   = m_fault_q;
    m_regAddr_d = m_regAddr_q;
    m_regData_d = m_regData_q;
    if (pass_through) begin
      m_valid_d   = 1'b1;
      m_regW_d    = bus.e_regW && !dec_fault;
      m_fault_d   = dec_fault;
      m_regAddr_d = bus.e_regAddr;
      m_regData_d = bus.e_regData;
    end else if (rsp_fire) begin
      m_valid_d   = 1'b1;
      m_regW_d    = ld_q && regW_q;
      m_fault_d   = 1'b0;
      m_regAddr_d = regAddr_q;
      m_regData_d = ld_q ? ld_data : DATA_WIDTH'(addr_q);
    end else if (bus.m_ready) begin
      m_valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q   <= 1'b0;
      m_regW_q    <= 1'b0;
      m_fault_q   <= 1'b0;
      m_regAddr_q <= '0;
      m_regData_q <= '0;
    end else begin
      m_valid_q   <= m_valid_d;
      m_regW_q    <= m_regW_d;
      m_fault_q   <= m_fault_d;
      m_regAddr_q <= m_regAddr_d;
      m_regData_q <= m_regData_d;
    end
  end

  always_comb begin
    bus.m_valid   = m_valid_q;
    bus.m_regW    = m_regW_q;
    bus.m_fault   = m_fault_q;
    bus.m_regAddr = m_regAddr_q;
    bus.m_regData = m_regData_q;
  end
endmodule

// File: tb/tb_lsu_pipe.sv
module tb_lsu_pipe;
  typedef struct packed {
    logic        e_ready;
    logic        m_valid;
    logic        m_regW;
    logic        m_fault;
    logic [4:0]  m_regAddr;
    logic [63:0] m_regData;
    logic        mem_req_valid;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wstrb;
    logic        mem_rsp_ready;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;            // 0: 32-bit DUT, 1: 64-bit DUT
  logic        e_valid, e_regW;
  logic [4:0]  e_regAddr;
  logic [63:0] e_regData, e_sdata, rdata;
  logic [2:0]  e_load, e_store;
  logic        m_ready, mem_req_ready, mem_rsp_valid;

  int errors = 0;
  int checks = 0;

  obs_t o, ob_req, ob_m;
  int   ob_lat, ob_req_cycle;
  bit   ob_req_seen, ob_req_stable, ob_eready;

  always #5 clk = ~clk;

  lsu_pipe_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .PADDR_WIDTH(32)) b32 ();
  lsu_pipe_if #(.ADDR_WIDTH(5), .DATA_WIDTH(64), .PADDR_WIDTH(32)) b64 ();

  lsu_pipe #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .PADDR_WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(b32));
  lsu_pipe #(.ADDR_WIDTH(5), .DATA_WIDTH(64), .PADDR_WIDTH(32)) u64 (.clk(clk), .rst(rst), .bus(b64));

  assign b32.e_valid       = e_valid && !sel;
  assign b32.e_regW        = e_regW;
  assign b32.e_regAddr     = e_regAddr;
  assign b32.e_regData     = e_regData[31:0];
  assign b32.e_load_inst   = e_load;
  assign b32.e_store_inst  = e_store;
  assign b32.e_store_data  = e_sdata[31:0];
  assign b32.m_ready       = m_ready;
  assign b32.mem_req_ready = mem_req_ready;
  assign b32.mem_rsp_valid = mem_rsp_valid;
  assign b32.mem_rsp_rdata = rdata[31:0];

  assign b64.e_valid       = e_valid && sel;
  assign b64.e_regW        = e_regW;
  assign b64.e_regAddr     = e_regAddr;
  assign b64.e_regData     = e_regData;
  assign b64.e_load_inst   = e_load;
  assign b64.e_store_inst  = e_store;
  assign b64.e_store_data  = e_sdata;
  assign b64.m_ready       = m_ready;
  assign b64.mem_req_ready = mem_req_ready;
  assign b64.mem_rsp_valid = mem_rsp_valid;
  assign b64.mem_rsp_rdata = rdata;

  always_comb begin
    o = '0;
    if (sel) begin
      o.e_ready = b64.e_ready;  o.m_valid = b64.m_valid;  o.m_regW = b64.m_regW;
      o.m_fault = b64.m_fault;  o.m_regAddr = b64.m_regAddr;  o.m_regData = b64.m_regData;
      o.mem_req_valid = b64.mem_req_valid;  o.mem_req_we = b64.mem_req_we;
      o.mem_req_addr = b64.mem_req_addr;  o.mem_req_wdata = b64.mem_req_wdata;
      o.mem_req_wstrb = b64.mem_req_wstrb;  o.mem_rsp_ready = b64.mem_rsp_ready;
    end else begin
      o.e_ready = b32.e_ready;  o.m_valid = b32.m_valid;  o.m_regW = b32.m_regW;
      o.m_fault = b32.m_fault;  o.m_regAddr = b32.m_regAddr;  o.m_regData = {32'd0, b32.m_regData};
      o.mem_req_valid = b32.mem_req_valid;  o.mem_req_we = b32.mem_req_we;
      o.mem_req_addr = b32.mem_req_addr;  o.mem_req_wdata = {32'd0, b32.mem_req_wdata};
      o.mem_req_wstrb = {4'd0, b32.mem_req_wstrb};  o.mem_rsp_ready = b32.mem_rsp_ready;
    end
  end

  // ------------------------------------------------------ reference model
  function automatic int size_of(input int ld, input int st);
    if (ld != 0) return (ld == 1 || ld == 4) ? 1 : (ld == 2 || ld == 5) ? 2 : (ld == 7) ? 8 : 4;
    return (st == 2) ? 2 : (st == 3) ? 4 : (st == 4) ? 8 : 1;
  endfunction

  function automatic bit model_fault(input int dw, input int ld, input int st, input logic [63:0] addr);
    if (ld != 0) begin
      if (dw == 32 && ld >= 6) return 1'b1;
    end else if (st != 0) begin
      if (st >= 5 || (dw == 32 && st == 4)) return 1'b1;
    end else return 1'b0;
    return (addr % size_of(ld, st)) != 0;
  endfunction

  function automatic logic [63:0] model_load(input int dw, input int ld, input logic [63:0] addr,
                                             input logic [63:0] rd);
    int          sz  = size_of(ld, 0);
    int          off = int'(addr % (dw / 8));
    logic [63:0] m, v;
    v = rd >> (8 * off);
    if (sz < 8) begin
      m = (64'd1 << (8 * sz)) - 64'd1;
      v = v & m;
      if ((ld == 1 || ld == 2 || ld == 3) && v[8*sz-1]) v = v | ~m;
    end
    if (dw == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  // Drives one op and plays the memory slave with the given stall counts.
  // Records observations only; the calling test does the comparing.
  task automatic run_op(input logic s, input logic regw, input logic [4:0] ra, input logic [63:0] rd,
                        input logic [2:0] ld, input logic [2:0] st, input logic [63:0] sd,
                        input logic [63:0] rdat, input int req_stall, input int rsp_stall, input bit noise);
    int rqs = req_stall;
    int rss = rsp_stall;
    sel = s;
    @(negedge clk);
    e_valid = 1'b1; e_regW = regw; e_regAddr = ra; e_regData = rd;
    e_load = ld; e_store = st; e_sdata = sd; m_ready = 1'b1;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    #1 ob_eready = o.e_ready;
    ob_lat = -1; ob_req_seen = 1'b0; ob_req_stable = 1'b1; ob_req_cycle = -1;
    @(negedge clk);
    e_valid = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      #1;
      if (o.m_valid) begin
        ob_lat = k; ob_m = o;
        break;
      end
      if (o.mem_req_valid) begin
        if (!ob_req_seen) begin
          ob_req_seen = 1'b1; ob_req_cycle = k; ob_req = o;
        end else if (o.mem_req_addr !== ob_req.mem_req_addr || o.mem_req_we !== ob_req.mem_req_we ||
                     o.mem_req_wdata !== ob_req.mem_req_wdata || o.mem_req_wstrb !== ob_req.mem_req_wstrb)
          ob_req_stable = 1'b0;
        mem_req_ready = (rqs == 0);
        if (rqs > 0) rqs--;
      end else mem_req_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (o.mem_rsp_ready) begin
        mem_rsp_valid = (rss == 0);
        rdata = (rss == 0) ? rdat : {$urandom, $urandom};
        if (rss > 0) rss--;
      end else begin
        mem_rsp_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        rdata = {$urandom, $urandom};
      end
      @(negedge clk);
    end
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset;
    rst = 1'b1; sel = 1'b0; e_valid = 1'b0; e_regW = 1'b0; e_regAddr = '0; e_regData = '0;
    e_load = '0; e_store = '0; e_sdata = '0; rdata = '0;
    m_ready = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      checks++;
      if ({o.m_valid, o.m_regW, o.m_fault, o.mem_req_valid, o.mem_rsp_ready} !== 5'b0) begin
        errors++; $display("FAIL reset_flags dut%0d got %b want 00000", s,
                           {o.m_valid, o.m_regW, o.m_fault, o.mem_req_valid, o.mem_rsp_ready});
      end
      checks++;
      if (o.m_regAddr !== 5'd0 || o.m_regData !== 64'd0) begin
        errors++; $display("FAIL reset_data dut%0d got addr=%h data=%h want 0", s, o.m_regAddr, o.m_regData);
      end
    end
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      checks++;
      if (o.e_ready !== 1'b1) begin errors++; $display("FAIL reset_e_ready dut%0d got %b want 1", s, o.e_ready); end
    end
  endtask

  task automatic test_lb;
    run_op(1'b0, 1'b1, 5'd7, 64'h1000_0003, 3'd1, 3'd0, 64'd0, 64'h80FF_0000, 0, 0, 1'b0);
    checks++;
    if (ob_lat !== 3) begin errors++; $display("FAIL lb_latency got %0d want 3", ob_lat); end
    checks++;
    if (ob_req_cycle !== 1 || ob_req.mem_req_addr !== 32'h1000_0000 || ob_req.mem_req_wstrb !== 8'h0 ||
        ob_req.mem_req_we !== 1'b0) begin
      errors++; $display("FAIL lb_request got cyc=%0d addr=%h strb=%h we=%b want 1 10000000 00 0",
                         ob_req_cycle, ob_req.mem_req_addr, ob_req.mem_req_wstrb, ob_req.mem_req_we);
    end
    checks++;
    if (ob_m.m_regData !== 64'hFFFF_FF80 || ob_m.m_regW !== 1'b1 || ob_m.m_regAddr !== 5'd7 || ob_m.m_fault !== 1'b0) begin
      errors++; $display("FAIL lb_result got data=%h w=%b a=%0d f=%b want ffffff80 1 7 0",
                         ob_m.m_regData, ob_m.m_regW, ob_m.m_regAddr, ob_m.m_fault);
    end
  endtask

  task automatic test_sh_stall;
    run_op(1'b0, 1'b1, 5'd3, 64'h2002, 3'd0, 3'd2, 64'h1234_ABCD, 64'd0, 4, 0, 1'b0);
    checks++;
    if (ob_lat !== 7) begin errors++; $display("FAIL sh_latency got %0d want 7", ob_lat); end
    checks++;
    if (ob_req.mem_req_wdata !== 64'hABCD_0000 || ob_req.mem_req_wstrb !== 8'b1100 ||
        ob_req.mem_req_we !== 1'b1 || ob_req.mem_req_addr !== 32'h2000) begin
      errors++; $display("FAIL sh_request got wdata=%h strb=%b we=%b addr=%h want abcd0000 1100 1 2000",
                         ob_req.mem_req_wdata, ob_req.mem_req_wstrb, ob_req.mem_req_we, ob_req.mem_req_addr);
    end
    checks++;
    if (ob_req_stable !== 1'b1) begin errors++; $display("FAIL sh_stable got %b want 1", ob_req_stable); end
    checks++;
    if (ob_m.m_regW !== 1'b0 || ob_m.m_regData !== 64'h2002 || ob_m.m_fault !== 1'b0) begin
      errors++; $display("FAIL sh_result got w=%b data=%h f=%b want 0 2002 0", ob_m.m_regW, ob_m.m_regData, ob_m.m_fault);
    end
  endtask

  task automatic test_fault;
    // {dut, load, store, addr}: lw misaligned, ld on 32, sd on 32, store 5 on 64
    logic [0:0]  fs[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0]  fl[4] = '{3'd3, 3'd7, 3'd0, 3'd0};
    logic [2:0]  fst[4] = '{3'd0, 3'd0, 3'd4, 3'd5};
    logic [63:0] fa[4] = '{64'h2001, 64'h3000, 64'h3008, 64'h4000};
    for (int i = 0; i < 4; i++) begin
      run_op(fs[i], 1'b1, 5'd9, fa[i], fl[i], fst[i], 64'h55, 64'd0, 0, 0, 1'b0);
      checks++;
      if (ob_lat !== 1 || ob_req_seen !== 1'b0) begin
        errors++; $display("FAIL fault_timing[%0d] got lat=%0d req=%b want 1 0", i, ob_lat, ob_req_seen);
      end
      checks++;
      if (ob_m.m_fault !== 1'b1 || ob_m.m_regW !== 1'b0 || ob_m.m_regData !== fa[i]) begin
        errors++; $display("FAIL fault_result[%0d] got f=%b w=%b data=%h want 1 0 %h",
                           i, ob_m.m_fault, ob_m.m_regW, ob_m.m_regData, fa[i]);
      end
    end
    // load code wins over an illegal store code
    run_op(1'b0, 1'b1, 5'd4, 64'h500, 3'd3, 3'd7, 64'd0, 64'hCAFE_F00D, 0, 0, 1'b0);
    checks++;
    if (ob_lat !== 3 || ob_m.m_fault !== 1'b0 || ob_m.m_regData !== 64'hCAFE_F00D) begin
      errors++; $display("FAIL load_priority got lat=%0d f=%b data=%h want 3 0 cafef00d",
                         ob_lat, ob_m.m_fault, ob_m.m_regData);
    end
  endtask

  task automatic test_dw64;
    run_op(1'b1, 1'b1, 5'd2, 64'h4004, 3'd6, 3'd0, 64'd0, 64'h8765_4321_0000_0000, 0, 0, 1'b0);
    checks++;
    if (ob_lat !== 3 || ob_m.m_regData !== 64'h0000_0000_8765_4321 || ob_req.mem_req_addr !== 32'h4000) begin
      errors++; $display("FAIL lwu64 got lat=%0d data=%h addr=%h want 3 0000000087654321 4000",
                         ob_lat, ob_m.m_regData, ob_req.mem_req_addr);
    end
    run_op(1'b1, 1'b1, 5'd2, 64'h4004, 3'd3, 3'd0, 64'd0, 64'h8765_4321_0000_0000, 0, 0, 1'b0);
    checks++;
    if (ob_m.m_regData !== 64'hFFFF_FFFF_8765_4321) begin
      errors++; $display("FAIL lw64 got data=%h want ffffffff87654321", ob_m.m_regData);
    end
    run_op(1'b1, 1'b0, 5'd2, 64'h10, 3'd0, 3'd4, 64'h0123_4567_89AB_CDEF, 64'd0, 1, 2, 1'b0);
    checks++;
    if (ob_lat !== 6 || ob_req.mem_req_wstrb !== 8'hFF || ob_req.mem_req_wdata !== 64'h0123_4567_89AB_CDEF) begin
      errors++; $display("FAIL sd64 got lat=%0d strb=%h wdata=%h want 6 ff 0123456789abcdef",
                         ob_lat, ob_req.mem_req_wstrb, ob_req.mem_req_wdata);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d[7];
    logic [4:0]  a[7];
    logic        w[7];
    for (int i = 0; i < 7; i++) begin
      d[i] = $urandom | 32'd1; a[i] = 5'($urandom_range(1, 31)); w[i] = 1'($urandom_range(0, 1));
    end
    sel = 1'b0; m_ready = 1'b1; e_load = '0; e_store = '0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      e_valid = 1'b1; e_regData = {32'd0, d[i]}; e_regAddr = a[i]; e_regW = w[i];
      #1;
      checks++;
      if (o.e_ready !== 1'b1) begin errors++; $display("FAIL b2b_e_ready[%0d] got %b want 1", i, o.e_ready); end
      @(negedge clk);
      #1;
      checks++;
      if (o.m_valid !== 1'b1 || o.m_regData !== {32'd0, d[i]} || o.m_regAddr !== a[i] || o.m_regW !== w[i]) begin
        errors++; $display("FAIL b2b_result[%0d] got v=%b data=%h a=%0d w=%b want 1 %h %0d %b",
                           i, o.m_valid, o.m_regData, o.m_regAddr, o.m_regW, d[i], a[i], w[i]);
      end
    end
    // writeback stalls two cycles with a new op waiting
    e_regData = {32'd0, d[6]}; e_regAddr = a[6]; e_regW = w[6]; m_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (o.e_ready !== 1'b0 || o.m_valid !== 1'b1 || o.m_regData !== {32'd0, d[5]} || o.m_regAddr !== a[5]) begin
        errors++; $display("FAIL b2b_hold[%0d] got er=%b v=%b data=%h a=%0d want 0 1 %h %0d",
                           c, o.e_ready, o.m_valid, o.m_regData, o.m_regAddr, d[5], a[5]);
      end
    end
    m_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (o.m_valid !== 1'b1 || o.m_regData !== {32'd0, d[6]}) begin
      errors++; $display("FAIL b2b_resume got v=%b data=%h want 1 %h", o.m_valid, o.m_regData, d[6]);
    end
    e_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (o.m_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", o.m_valid); end
  endtask

  task automatic test_reset_mid;
    sel = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    e_valid = 1'b1; e_regW = 1'b1; e_regAddr = 5'd12; e_regData = 64'h100; e_load = 3'd3; e_store = 3'd0;
    @(negedge clk);
    e_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    #1;
    checks++;
    if (o.mem_rsp_ready !== 1'b1) begin errors++; $display("FAIL midrst_wait got %b want 1", o.mem_rsp_ready); end
    rst = 1'b1;
    #1;
    checks++;
    if ({o.m_valid, o.m_regW, o.m_fault, o.mem_req_valid, o.mem_rsp_ready} !== 5'b0 ||
        o.m_regAddr !== 5'd0 || o.m_regData !== 64'd0) begin
      errors++; $display("FAIL midrst_outputs got flags=%b a=%0d data=%h want 00000 0 0",
                         {o.m_valid, o.m_regW, o.m_fault, o.mem_req_valid, o.mem_rsp_ready}, o.m_regAddr, o.m_regData);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(1'b0, 1'b1, 5'd13, 64'h1000_0001, 3'd4, 3'd0, 64'd0, 64'h0000_9A00, 0, 0, 1'b0);
    checks++;
    if (ob_lat !== 3 || ob_m.m_regData !== 64'h9A || ob_m.m_regAddr !== 5'd13) begin
      errors++; $display("FAIL midrst_next got lat=%0d data=%h a=%0d want 3 9a 13", ob_lat, ob_m.m_regData, ob_m.m_regAddr);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 60; n++) begin
      logic        s, regw, f, memop;
      logic [2:0]  ld, st;
      logic [4:0]  ra;
      logic [63:0] mask, rd, sd, rdat, exp_data;
      int          kind, dw, rqs, rss, off, sz, exp_lat;
      logic [31:0] base;
      s = 1'($urandom_range(0, 1)); dw = s ? 64 : 32;
      mask = s ? '1 : 64'hFFFF_FFFF;
      kind = $urandom_range(0, 3);
      ld = (kind == 1 || kind == 3) ? 3'($urandom_range(1, 7)) : 3'd0;
      st = (kind == 2 || kind == 3) ? 3'($urandom_range(1, 7)) : 3'd0;
      base = $urandom;
      if ($urandom_range(0, 3) != 0) base = base & ~32'd7;
      rd = (kind == 0) ? ({$urandom, $urandom} & mask) : {32'd0, base};
      sd = {$urandom, $urandom} & mask; rdat = {$urandom, $urandom} & mask;
      ra = 5'($urandom); regw = 1'($urandom_range(0, 1));
      rqs = $urandom_range(0, 3); rss = $urandom_range(0, 3);
      run_op(s, regw, ra, rd, ld, st, sd, rdat, rqs, rss, 1'b1);

      f = model_fault(dw, ld, st, rd);
      memop = (ld != 0 || st != 0) && !f;
      exp_lat = memop ? 3 + rqs + rss : 1;
      off = int'(rd % (dw / 8)); sz = size_of(ld, st);
      exp_data = !memop ? rd : (ld != 0) ? model_load(dw, ld, rd, rdat) : (rd & 64'hFFFF_FFFF);
      checks++;
      if (ob_eready !== 1'b1 || ob_lat !== exp_lat || ob_req_seen !== memop) begin
        errors++; $display("FAIL rnd_timing[%0d] got er=%b lat=%0d req=%b want 1 %0d %b",
                           n, ob_eready, ob_lat, ob_req_seen, exp_lat, memop);
      end
      if (memop) begin
        logic [31:0] ea;
        logic [7:0]  es;
        logic [63:0] ew;
        ea = rd[31:0] & ~32'(dw / 8 - 1);
        es = (ld != 0) ? 8'd0 : 8'(((1 << sz) - 1) << off);
        ew = (ld != 0) ? ob_req.mem_req_wdata : ((sd << (8 * off)) & mask);
        checks++;
        if (ob_req.mem_req_addr !== ea || ob_req.mem_req_we !== (ld == 0) || ob_req.mem_req_wstrb !== es ||
            ob_req.mem_req_wdata !== ew || ob_req_stable !== 1'b1) begin
          errors++; $display("FAIL rnd_request[%0d] got addr=%h we=%b strb=%h wdata=%h stable=%b want %h %b %h %h 1",
                             n, ob_req.mem_req_addr, ob_req.mem_req_we, ob_req.mem_req_wstrb,
                             ob_req.mem_req_wdata, ob_req_stable, ea, (ld == 0), es, ew);
        end
      end
      checks++;
      if (ob_m.m_regData !== exp_data || ob_m.m_fault !== f || ob_m.m_regAddr !== ra ||
          ob_m.m_regW !== (memop ? (regw && ld != 0) : (regw && !f))) begin
        errors++; $display("FAIL rnd_result[%0d] ld=%0d st=%0d got data=%h f=%b a=%0d w=%b want %h %b %0d %b",
                           n, ld, st, ob_m.m_regData, ob_m.m_fault, ob_m.m_regAddr, ob_m.m_regW,
                           exp_data, f, ra, (memop ? (regw && ld != 0) : (regw && !f)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_lb();
    test_sh_stall();
    test_fault();
    test_dw64();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
